// File: rtl/complex_div_seq_pkg.sv
// complex_div_seq_pkg: shared FSM encoding and sizing helper for the complex divider
package complex_div_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PROD = 3'd1,
      S_SUM  = 3'd2,
      S_DIV  = 3'd3,
      S_DONE = 3'd4
   } state_t;
   function automatic int cnt_width(input int d);
      return $clog2(d);
   endfunction
endpackage

// File: rtl/complex_div_seq_if.sv
// complex_div_seq_if: operand/result handshake bundle of the complex divider
//   I_data1_i/q, I_data2_i/q : numerator and denominator components, signed
//   I_data_v / O_ready       : input handshake
//   O_data_i/q, O_div_zero   : quotient and divide-by-zero flag
//   O_data_v / I_ready       : output handshake
interface complex_div_seq_if #(
   parameter int C_DIN_WIDTH  = 16,
   parameter int C_DOUT_WIDTH = 32
);
   logic signed [C_DIN_WIDTH-1:0]  I_data1_i, I_data1_q, I_data2_i, I_data2_q;
   logic                           I_data_v, O_ready;
   logic signed [C_DOUT_WIDTH-1:0] O_data_i, O_data_q;
   logic                           O_div_zero, O_data_v, I_ready;
   modport master (
      output I_data1_i, I_data1_q, I_data2_i, I_data2_q, I_data_v, I_ready,
      input  O_ready, O_data_i, O_data_q, O_div_zero, O_data_v
   );
   modport slave (
      input  I_data1_i, I_data1_q, I_data2_i, I_data2_q, I_data_v, I_ready,
      output O_ready, O_data_i, O_data_q, O_div_zero, O_data_v
   );
endinterface

// File: rtl/complex_div_seq_step.sv
// complex_div_seq_step: one restoring-division bit step (shift in, compare, subtract)
//   rem    : partial remainder, always < den
//   den    : divisor
//   bit_in : next dividend bit, MSB first
//   rem_n  : updated remainder
//   q      : quotient bit produced by this step
module complex_div_seq_step #(
   parameter int C_W = 32
) (
   input  logic [C_W-1:0] rem,
   input  logic [C_W-1:0] den,
   input  logic           bit_in,
   output logic [C_W-1:0] rem_n,
   output logic           q
);
   logic [C_W:0] t;
   always_comb begin
      t     = {rem, bit_in};
      q     = t >= {1'b0, den};
      rem_n = C_W'(q ? t - {1'b0, den} : t);
   end
endmodule

// File: rtl/complex_div_seq.sv
// complex_div_seq: sequential fixed-point complex divider (a+jb)/(c+jd)
//   I_clk   : clock, rising edge
//   I_rst_n : asynchronous reset, active low
//   bus     : operand/result handshake (slave side), see complex_div_seq_if
module complex_div_seq
   import complex_div_seq_pkg::*;
#(
   parameter int C_DIN_WIDTH  = 16,
   parameter int C_FRAC_BITS  = 14,
   parameter int C_DOUT_WIDTH = 32
) (
   input logic               I_clk,
   input logic               I_rst_n,
   complex_div_seq_if.slave  bus
);
   localparam int W  = C_DIN_WIDTH;
   localparam int F  = C_FRAC_BITS;
   localparam int D  = C_DOUT_WIDTH;
   localparam int MW = 2 * W;
   localparam int SW = MW + 1;
   localparam int NW = SW + F;
   localparam int XW = NW + D;
   localparam int CW = cnt_width(D);

   state_t                state, state_n;
   logic signed [W-1:0]   a_r, b_r, c_r, d_r;
   logic signed [MW-1:0]  ac, bd, bc, ad;
   logic signed [SW-1:0]  sum_i, sum_q;
   logic [SW-1:0]         mag_i, mag_q;
   logic [NW-1:0]         sh_i, sh_q, nx_i, nx_q;
   logic [MW-1:0]         den_s, den, rem_i, rem_q, rem_i_n, rem_q_n;
   logic [D-2:0]          q_i, q_q;
   logic [CW-1:0]         cnt;
   logic                  sgn_i, sgn_q, ovf_i, ovf_q, dz, qb_i, qb_q, accept, take;

   // Sign-magnitude to D-bit result; saturation is symmetric (+/-(2^(D-1)-1)).
   function automatic logic [D-1:0] fmt(input logic z, input logic s, input logic sat,
                                        input logic [D-2:0] q);
      logic [D-1:0] m;
      m = {1'b0, sat ? {(D-1){1'b1}} : q};
      return z ? '0 : (s ? -m : m);
   endfunction

   always_comb begin
      accept      = bus.I_data_v && state == S_IDLE;
      take        = bus.O_data_v && bus.I_ready;
      bus.O_ready = state == S_IDLE;
      sum_i       = SW'(ac) + SW'(bd);
      sum_q       = SW'(bc) - SW'(ad);
      mag_i       = sum_i[SW-1] ? -sum_i : sum_i;
      mag_q       = sum_q[SW-1] ? -sum_q : sum_q;
      sh_i        = {mag_i, {F{1'b0}}};
      sh_q        = {mag_q, {F{1'b0}}};
      den_s       = MW'(MW'(c_r) * MW'(c_r) + MW'(d_r) * MW'(d_r));
      state_n     = state;
      case (state)
         S_IDLE:  state_n = accept ? S_PROD : S_IDLE;
         S_PROD:  state_n = S_SUM;
         S_SUM:   state_n = S_DIV;
         S_DIV:   state_n = cnt == '0 ? S_DONE : S_DIV;
         S_DONE:  state_n = take ? S_IDLE : S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   complex_div_seq_step #(.C_W(MW)) u_step_i (
      .rem(rem_i), .den(den), .bit_in(nx_i[cnt]), .rem_n(rem_i_n), .q(qb_i)
   );
   complex_div_seq_step #(.C_W(MW)) u_step_q (
      .rem(rem_q), .den(den), .bit_in(nx_q[cnt]), .rem_n(rem_q_n), .q(qb_q)
   );

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state          <= S_IDLE;
         {a_r, b_r, c_r, d_r} <= '0;
         {ac, bd, bc, ad}     <= '0;
         {nx_i, nx_q, den, rem_i, rem_q, q_i, q_q, cnt} <= '0;
         {sgn_i, sgn_q, ovf_i, ovf_q, dz} <= '0;
         bus.O_data_i   <= '0;
         bus.O_data_q   <= '0;
         bus.O_div_zero <= 1'b0;
         bus.O_data_v   <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            a_r <= bus.I_data1_i;
            b_r <= bus.I_data1_q;
            c_r <= bus.I_data2_i;
            d_r <= bus.I_data2_q;
         end
         if (state == S_PROD) begin
            ac <= MW'(a_r) * MW'(c_r);
            bd <= MW'(b_r) * MW'(d_r);
            bc <= MW'(b_r) * MW'(c_r);
            ad <= MW'(a_r) * MW'(d_r);
         end
         // The top D-1 bits of the scaled dividend seed the remainder; without
         // overflow that seed is already below den, so D-1 steps suffice.
         if (state == S_SUM) begin
            nx_i  <= sh_i;
            nx_q  <= sh_q;
            den   <= den_s;
            rem_i <= MW'(sh_i >> (D - 1));
            rem_q <= MW'(sh_q >> (D - 1));
            sgn_i <= sum_i[SW-1];
            sgn_q <= sum_q[SW-1];
            ovf_i <= XW'(sh_i) >= (XW'(den_s) << (D - 1));
            ovf_q <= XW'(sh_q) >= (XW'(den_s) << (D - 1));
            dz    <= den_s == '0;
            cnt   <= CW'(D - 2);
         end
         if (state == S_DIV) begin
            rem_i <= rem_i_n;
            rem_q <= rem_q_n;
            q_i   <= {q_i[D-3:0], qb_i};
            q_q   <= {q_q[D-3:0], qb_q};
            cnt   <= cnt - 1'b1;
         end
         // With a zero denominator the product sums are zero, so the saturation
         // direction comes from the raw numerator components instead.
         if (state == S_DONE && !bus.O_data_v) begin
            bus.O_data_i   <= fmt(dz && a_r == '0, dz ? a_r[W-1] : sgn_i, dz || ovf_i, q_i);
            bus.O_data_q   <= fmt(dz && b_r == '0, dz ? b_r[W-1] : sgn_q, dz || ovf_q, q_q);
            bus.O_div_zero <= dz;
            bus.O_data_v   <= 1'b1;
         end else if (take) begin
            bus.O_data_v <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_complex_div_seq.sv
// tb_complex_div_seq: scoreboard bench for complex_div_seq at D=32 and D=24
module tb_complex_div_seq;
   logic I_clk   = 1'b0;
   logic I_rst_n = 1'b0;
   always #5 I_clk = ~I_clk;

   complex_div_seq_if #(.C_DIN_WIDTH(16), .C_DOUT_WIDTH(32)) bus0 ();
   complex_div_seq_if #(.C_DIN_WIDTH(16), .C_DOUT_WIDTH(24)) bus1 ();

   complex_div_seq #(.C_DIN_WIDTH(16), .C_FRAC_BITS(14), .C_DOUT_WIDTH(32)) u0 (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .bus(bus0)
   );
   complex_div_seq #(.C_DIN_WIDTH(16), .C_FRAC_BITS(14), .C_DOUT_WIDTH(24)) u1 (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .bus(bus1)
   );

   typedef struct {
      longint i;
      longint q;
      logic   dz;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint comp(input longint num, input longint raw, input longint den);
      longint m, qv;
      if (den == 0) return raw == 0 ? 64'sd0 : (raw > 0 ? 64'sd2147483647 : -64'sd2147483647);
      m  = num < 0 ? -num : num;
      qv = (m * 16384) / den;
      if (qv > 2147483647) qv = 2147483647;
      return num < 0 ? -qv : qv;
   endfunction

   always @(negedge I_clk) begin
      if (I_rst_n && bus0.O_data_v && bus0.I_ready) begin
         if (q0.size() == 0) check("sb0_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q0.pop_front();
            check("sb0_i", longint'(bus0.O_data_i), e.i);
            check("sb0_q", longint'(bus0.O_data_q), e.q);
            check("sb0_dz", longint'(bus0.O_div_zero), longint'(e.dz));
         end
      end
      if (I_rst_n && bus1.O_data_v && bus1.I_ready) begin
         if (q1.size() == 0) check("sb1_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            check("sb1_i", longint'(bus1.O_data_i), e.i);
            check("sb1_q", longint'(bus1.O_data_q), e.q);
            check("sb1_dz", longint'(bus1.O_div_zero), longint'(e.dz));
         end
      end
   end

   // Called and returns at 1 time unit after a rising edge; returns just after the accept edge.
   task automatic send(input int sel, input int a, input int b, input int c, input int d,
                       input longint ei, input longint eq, input logic edz, input bit push);
      int   n;
      exp_t e;
      n = 0;
      while (!(sel != 0 ? bus1.O_ready : bus0.O_ready) && n < 200) begin
         @(posedge I_clk);
         #1;
         n++;
      end
      if (n >= 200) check("ready_timeout", 0, 1);
      if (sel != 0) begin
         bus1.I_data1_i = 16'(a);
         bus1.I_data1_q = 16'(b);
         bus1.I_data2_i = 16'(c);
         bus1.I_data2_q = 16'(d);
         bus1.I_data_v  = 1'b1;
      end else begin
         bus0.I_data1_i = 16'(a);
         bus0.I_data1_q = 16'(b);
         bus0.I_data2_i = 16'(c);
         bus0.I_data2_q = 16'(d);
         bus0.I_data_v  = 1'b1;
      end
      e.i  = ei;
      e.q  = eq;
      e.dz = edz;
      if (push && sel != 0) q1.push_back(e);
      if (push && sel == 0) q0.push_back(e);
      @(posedge I_clk);
      #1;
      bus0.I_data_v = 1'b0;
      bus1.I_data_v = 1'b0;
   endtask

   task automatic latency(input int sel, input int exp_n);
      int n;
      n = 0;
      while (n < 60) begin
         @(posedge I_clk);
         #1;
         n++;
         if (sel != 0 ? bus1.O_data_v : bus0.O_data_v) break;
      end
      check(sel != 0 ? "latency_d24" : "latency_d32", n, exp_n);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
         @(posedge I_clk);
         #1;
         n++;
      end
      check("drain", q0.size() + q1.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int     a, b, c, d, n, hi;
      longint ni, nq, dn;
      bus0.I_data_v = 1'b0;
      bus1.I_data_v = 1'b0;
      bus0.I_ready  = 1'b1;
      bus1.I_ready  = 1'b1;
      {bus0.I_data1_i, bus0.I_data1_q, bus0.I_data2_i, bus0.I_data2_q} = '0;
      {bus1.I_data1_i, bus1.I_data1_q, bus1.I_data2_i, bus1.I_data2_q} = '0;
      repeat (3) @(posedge I_clk);
      #1;
      check("rst_ready", bus0.O_ready, 1);
      check("rst_valid", bus0.O_data_v, 0);
      check("rst_data_i", longint'(bus0.O_data_i), 0);
      check("rst_data_q", longint'(bus0.O_data_q), 0);
      check("rst_dz", bus0.O_div_zero, 0);
      check("rst_ready_d24", bus1.O_ready, 1);
      I_rst_n = 1'b1;
      @(posedge I_clk);
      #1;
      send(0, 16384, 0, 16384, 0, 16384, 0, 1'b0, 1'b1);
      latency(0, 34);
      send(0, 3, 4, 1, 2, 36044, -6553, 1'b0, 1'b1);
      send(0, 5, -3, 0, 0, 2147483647, -2147483647, 1'b1, 1'b1);
      send(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
      send(0, -16384, 16384, 0, 16384, 16384, 16384, 1'b0, 1'b1);
      send(0, -32768, -32768, -32768, 0, 16384, 16384, 1'b0, 1'b1);
      send(0, 32767, 0, 3, 0, 178951509, 0, 1'b0, 1'b1);
      send(0, -32767, 0, 3, 0, -178951509, 0, 1'b0, 1'b1);
      send(0, 0, 0, 3, 1, 0, 0, 1'b0, 1'b1);
      send(1, 32767, 0, 1, 0, 8388607, 0, 1'b0, 1'b1);
      latency(1, 26);
      send(1, -32768, 0, 1, 0, -8388607, 0, 1'b0, 1'b1);
      send(1, 3, 4, 1, 2, 36044, -6553, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         a  = int'($urandom_range(65535)) - 32768;
         b  = int'($urandom_range(65535)) - 32768;
         c  = k < 3 ? int'($urandom_range(15)) - 8 : int'($urandom_range(65535)) - 32768;
         d  = int'($urandom_range(65535)) - 32768;
         ni = longint'(a) * c + longint'(b) * d;
         nq = longint'(b) * c - longint'(a) * d;
         dn = longint'(c) * c + longint'(d) * d;
         send(0, a, b, c, d, comp(ni, a, dn), comp(nq, b, dn), dn == 0, 1'b1);
      end
      drain();
      bus0.I_ready = 1'b0;
      send(0, 3, 4, 1, 2, 36044, -6553, 1'b0, 1'b1);
      n = 0;
      while (!bus0.O_data_v && n < 60) begin
         @(posedge I_clk);
         #1;
         n++;
      end
      check("bp_valid_rise", bus0.O_data_v, 1);
      for (int k = 0; k < 10; k++) begin
         @(posedge I_clk);
         #1;
         check("bp_valid", bus0.O_data_v, 1);
         check("bp_data_i", longint'(bus0.O_data_i), 36044);
         check("bp_data_q", longint'(bus0.O_data_q), -6553);
         check("bp_ready", bus0.O_ready, 0);
      end
      bus0.I_ready   = 1'b1;
      bus0.I_data1_i = 16'sd16384;
      bus0.I_data1_q = 16'sd0;
      bus0.I_data2_i = 16'sd16384;
      bus0.I_data2_q = 16'sd0;
      bus0.I_data_v  = 1'b1;
      q0.push_back('{i: 16384, q: 0, dz: 1'b0});
      @(posedge I_clk);
      #1;
      check("pulse_valid_drop", bus0.O_data_v, 0);
      check("pulse_ready_back", bus0.O_ready, 1);
      @(posedge I_clk);
      #1;
      check("pulse_accept", bus0.O_ready, 0);
      bus0.I_data_v = 1'b0;
      drain();
      send(0, 3, 4, 1, 2, 0, 0, 1'b0, 1'b0);
      repeat (10) @(posedge I_clk);
      #1;
      I_rst_n = 1'b0;
      #1;
      check("abort_valid", bus0.O_data_v, 0);
      check("abort_ready", bus0.O_ready, 1);
      check("abort_data_i", longint'(bus0.O_data_i), 0);
      check("abort_data_q", longint'(bus0.O_data_q), 0);
      check("abort_dz", bus0.O_div_zero, 0);
      @(posedge I_clk);
      #1;
      I_rst_n = 1'b1;
      hi = 0;
      repeat (45) begin
         @(posedge I_clk);
         #1;
         if (bus0.O_data_v || bus1.O_data_v) hi++;
      end
      check("abort_no_stale", hi, 0);
      check("abort_idle_ready", bus0.O_ready, 1);
      send(0, 3, 4, 1, 2, 36044, -6553, 1'b0, 1'b1);
      drain();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
